ddp_pixel_fetch: RTL and testbench



---
 rtl/ddp_pixel_fetch.sv | 196 +++++++++++++++++++
 tb/tb_ddp_pixel_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddp_pixel_fetch.sv
// rtl/ddp_pixel_fetch.sv - VGA pixel fetch: coordinates, upscaled frame-buffer reads, aligned RGB out
//
// Purpose: sits after the VGA timing generator. It turns hen/ven into pixel
// coordinates and frame-buffer read addresses. The low-resolution buffer is
// replicated SCALE times in both directions. The block registers the RAM word
// onto rgb and delays the sync strobes so every pin lags its input strobe by 3 clocks.
//
// Ports:
//   clk_px     pixel clock
//   rst        asynchronous active-high reset
//   hen, ven   horizontal / vertical display enables (de = hen & ven)
//   hs, vs     sync strobes from the timing generator
//   rd_en      frame-buffer read strobe (1 cycle after the pixel strobe)
//   rd_addr    frame-buffer read address, holds while rd_en is low
//   rd_data    frame-buffer word, valid 1 cycle after rd_en
//   rgb        pixel colour, 0 outside the active area
//   hs_o, vs_o sync strobes delayed 3 cycles
//   de_o       hen & ven delayed 3 cycles
//   px_x, px_y full-resolution coordinates of the pixel on rgb
//   frame_end  one-cycle pulse the cycle after ven falls (not pipelined)

module ddp_pixel_fetch #(
  parameter int H_ACT  = 800,
  parameter int V_ACT  = 600,
  parameter int SCALE  = 4,     // must be at least 1
  parameter int FB_W   = 200,
  parameter int FB_H   = 150,
  parameter int ADDR_W = 15,
  parameter int RGB_W  = 12
) (
  input  logic              clk_px,
  input  logic              rst,
  input  logic              hen,
  input  logic              ven,
  input  logic              hs,
  input  logic              vs,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RGB_W-1:0]  rd_data,
  output logic [RGB_W-1:0]  rgb,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic [9:0]        px_x,
  output logic [9:0]        px_y,
  output logic              frame_end
);

  localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FXW = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int FYW = (FB_H > 1) ? $clog2(FB_H) : 1;

  localparam logic [9:0]     X_MAX  = 10'(H_ACT - 1);
  localparam logic [9:0]     Y_MAX  = 10'(V_ACT - 1);
  localparam logic [SW-1:0]  S_MAX  = SW'(SCALE - 1);
  localparam logic [FXW-1:0] FX_MAX = FXW'(FB_W - 1);
  localparam logic [FYW-1:0] FY_MAX = FYW'(FB_H - 1);

  logic              de;
  logic              line_end;

  logic [9:0]        x, y;
  logic [SW-1:0]     sx, sy;
  logic [FXW-1:0]    fb_x;
  logic [FYW-1:0]    fb_y;
  logic [ADDR_W-1:0] line_base;

  logic              hen_d1, ven_d1;
  logic              de_d1, de_d2;
  logic              hs_d1, hs_d2, vs_d1, vs_d2;
  logic [9:0]        x_d1, x_d2, y_d1, y_d2;

  assign de = hen & ven;
  // ven=0 wins over a simultaneous hen fall, so that edge never counts as a line.
  assign line_end = hen_d1 & ~hen & ven;

  // Horizontal position: x is the full-resolution column of the pixel being
  // presented this cycle; sx/fb_x split it into replica phase and buffer column.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      x    <= '0;
      sx   <= '0;
      fb_x <= '0;
    end else if (!de) begin
      x    <= '0;
      sx   <= '0;
      fb_x <= '0;
    end else begin
      if (x != X_MAX) x <= x + 10'd1;
      if (sx == S_MAX) begin
        sx <= '0;
        if (fb_x != FX_MAX) fb_x <= fb_x + FXW'(1);
      end else begin
        sx <= sx + SW'(1);
      end
    end
  end

  // Vertical position: line_base tracks fb_y * FB_W incrementally so the
  // address path is a single adder.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      y         <= '0;
      sy        <= '0;
      fb_y      <= '0;
      line_base <= '0;
    end else if (!ven) begin
      y         <= '0;
      sy        <= '0;
      fb_y      <= '0;
      line_base <= '0;
    end else if (line_end) begin
      if (y != Y_MAX) y <= y + 10'd1;
      if (sy == S_MAX) begin
        sy <= '0;
        if (fb_y != FY_MAX) begin
          fb_y      <= fb_y + FYW'(1);
          line_base <= line_base + ADDR_W'(FB_W);
        end
      end else begin
        sy <= sy + SW'(1);
      end
    end
  end

  // Edge detectors and the frame_end pulse.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      hen_d1    <= 1'b0;
      ven_d1    <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      hen_d1    <= hen;
      ven_d1    <= ven;
      frame_end <= ven_d1 & ~ven;
    end
  end

  // Stage 1: address issue; strobes and coordinates travel alongside.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      de_d1   <= 1'b0;
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      x_d1    <= '0;
      y_d1    <= '0;
    end else begin
      rd_en <= de;
      if (de) rd_addr <= line_base + ADDR_W'(fb_x);
      de_d1 <= de;
      hs_d1 <= hs;
      vs_d1 <= vs;
      x_d1  <= x;
      y_d1  <= y;
    end
  end

  // Stage 2: RAM access cycle; sidebands just wait for rd_data.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      de_d2 <= 1'b0;
      hs_d2 <= 1'b0;
      vs_d2 <= 1'b0;
      x_d2  <= '0;
      y_d2  <= '0;
    end else begin
      de_d2 <= de_d1;
      hs_d2 <= hs_d1;
      vs_d2 <= vs_d1;
      x_d2  <= x_d1;
      y_d2  <= y_d1;
    end
  end

  // Stage 3: output registers. rgb is blanked outside the active area.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      rgb  <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
      px_x <= '0;
      px_y <= '0;
    end else begin
      rgb  <= de_d2 ? rd_data : '0;
      de_o <= de_d2;
      hs_o <= hs_d2;
      vs_o <= vs_d2;
      px_x <= x_d2;
      px_y <= y_d2;
    end
  end

endmodule

// File: tb/tb_ddp_pixel_fetch.sv
// tb/tb_ddp_pixel_fetch.sv - self-checking bench for ddp_pixel_fetch

module tb_ddp_pixel_fetch;

  localparam int H_ACT  = 800;
  localparam int V_ACT  = 600;
  localparam int SCALE  = 4;
  localparam int FB_W   = 200;
  localparam int FB_H   = 150;
  localparam int ADDR_W = 15;
  localparam int RGB_W  = 12;

  logic              clk_px;
  logic              rst;
  logic              hen, ven, hs, vs;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [RGB_W-1:0]  rd_data;
  logic [RGB_W-1:0]  rgb;
  logic              hs_o, vs_o, de_o;
  logic [9:0]        px_x, px_y;
  logic              frame_end;

  int errors = 0;
  int checks = 0;
  int de_o_cnt = 0;
  int rd_en_cnt = 0;

  ddp_pixel_fetch #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .SCALE(SCALE), .FB_W(FB_W), .FB_H(FB_H),
    .ADDR_W(ADDR_W), .RGB_W(RGB_W)
  ) dut (
    .clk_px(clk_px), .rst(rst), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rgb(rgb),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .px_x(px_x), .px_y(px_y),
    .frame_end(frame_end)
  );

  initial begin
    clk_px = 1'b0;
    forever #5 clk_px = ~clk_px;
  end

  function automatic logic [RGB_W-1:0] ram_word(input int a);
    return RGB_W'((a * 37 + 5) & 32'hFFF);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Frame buffer: synchronous, one cycle of read latency.
  always @(posedge clk_px) begin
    rd_data <= rd_en ? ram_word(int'(rd_addr)) : 12'hF0F;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Model: pixel index within the run of de, line index within the frame,
  // mapped to buffer coordinates by division and clamping.
  int          m_pix = 0;
  int          m_line = 0;
  logic        m_prev_hen = 1'b0;
  logic        m_prev_ven = 1'b0;
  logic        exp_rd_en = 1'b0;
  int          exp_addr = 0;
  logic        exp_fe = 1'b0;
  logic [2:0]  s_de = '0;
  logic [2:0]  s_hs = '0;
  logic [2:0]  s_vs = '0;
  int          s_x[3];
  int          s_y[3];
  logic [RGB_W-1:0] s_rgb[3];

  always @(posedge clk_px) begin
    if (rst) begin
      m_pix = 0; m_line = 0; m_prev_hen = 1'b0; m_prev_ven = 1'b0;
      exp_rd_en = 1'b0; exp_addr = 0; exp_fe = 1'b0;
      s_de = '0; s_hs = '0; s_vs = '0;
      for (int i = 0; i < 3; i++) begin s_x[i] = 0; s_y[i] = 0; s_rgb[i] = '0; end
    end else begin
      logic de_now;
      int   a_now;
      de_now = hen & ven;
      a_now = imin(m_line / SCALE, FB_H - 1) * FB_W + imin(m_pix / SCALE, FB_W - 1);
      if (de_now) exp_addr = a_now;
      exp_rd_en = de_now;
      exp_fe = m_prev_ven & ~ven;
      for (int i = 2; i > 0; i--) begin
        s_x[i] = s_x[i-1]; s_y[i] = s_y[i-1]; s_rgb[i] = s_rgb[i-1];
      end
      s_de = {s_de[1:0], de_now};
      s_hs = {s_hs[1:0], hs};
      s_vs = {s_vs[1:0], vs};
      s_x[0] = imin(m_pix, H_ACT - 1);
      s_y[0] = imin(m_line, V_ACT - 1);
      s_rgb[0] = de_now ? ram_word(a_now) : '0;
      m_pix = de_now ? m_pix + 1 : 0;
      if (!ven) m_line = 0;
      else if (m_prev_hen && !hen) m_line = m_line + 1;
      m_prev_hen = hen;
      m_prev_ven = ven;
    end
  end

  always @(negedge clk_px) begin
    if (rst) begin
      chk("rst_ctl", 32'({rd_en, hs_o, vs_o, de_o, frame_end}), 32'd0);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      chk("rst_data", 32'({rgb, px_x}), 32'd0);
      chk("rst_py", 32'(px_y), 32'd0);
    end else begin
      chk("rd_en", 32'(rd_en), 32'(exp_rd_en));
      chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
      chk("frame_end", 32'(frame_end), 32'(exp_fe));
      chk("de_o", 32'(de_o), 32'(s_de[2]));
      chk("hs_o", 32'(hs_o), 32'(s_hs[2]));
      chk("vs_o", 32'(vs_o), 32'(s_vs[2]));
      chk("rgb", 32'(rgb), 32'(s_rgb[2]));
      if (s_de[2]) begin
        chk("px_x", 32'(px_x), 32'(s_x[2]));
        chk("px_y", 32'(px_y), 32'(s_y[2]));
      end
    end
    if (de_o === 1'b1) de_o_cnt++;
    if (rd_en === 1'b1) rd_en_cnt++;
  end

  task automatic step(input logic h, input logic v, input logic hsy, input logic vsy);
    hen = h; ven = v; hs = hsy; vs = vsy;
    @(posedge clk_px);
    #1;
  endtask

  task automatic blank_h();
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 0, 0);
  endtask

  task automatic short_line(input int n);
    step(1, 1, 0, 0); step(1, 1, 1'(n % 2), 0);
    step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 0, 0);
  endtask

  task automatic vblank();
    step(0, 0, 0, 0); step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 1, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_hs_o"}, 32'(hs_o), 32'd0);
    chk({tag, "_vs_o"}, 32'(vs_o), 32'd0);
    chk({tag, "_de_o"}, 32'(de_o), 32'd0);
    chk({tag, "_px_x"}, 32'(px_x), 32'd0);
    chk({tag, "_px_y"}, 32'(px_y), 32'd0);
    chk({tag, "_frame_end"}, 32'(frame_end), 32'd0);
  endtask

  initial begin
    int c_de, c_rd;
    rst = 1'b1;
    hen = 1'b1; ven = 1'b1; hs = 1'b1; vs = 1'b1;
    @(posedge clk_px); #1;
    @(posedge clk_px); #1;
    chk_all_zero("reset");
    hen = 1'b0; ven = 1'b0; hs = 1'b0; vs = 1'b0;
    rst = 1'b0;

    // hen with ven low never reads
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1);
      chk("rd_en_ven0", 32'(rd_en), 32'd0);
    end
    vblank();

    // Frame A, line 0 full width
    c_de = de_o_cnt; c_rd = rd_en_cnt;
    for (int k = 0; k < H_ACT; k++) begin
      step(1, 1, 0, 0);
      if (k == 0) begin
        chk("l0_first_rd_en", 32'(rd_en), 32'd1);
        chk("l0_first_addr", 32'(rd_addr), 32'd0);
      end
      if (k == 2) begin
        chk("l0_first_de_o", 32'(de_o), 32'd1);
        chk("l0_first_px_x", 32'(px_x), 32'd0);
        chk("l0_first_px_y", 32'(px_y), 32'd0);
        chk("l0_first_rgb", 32'(rgb), 32'd5);
      end
      if (k == 4) chk("l0_addr_px4", 32'(rd_addr), 32'd1);
      if (k == 10) chk("l0_rgb_px8", 32'(rgb), 32'd79);
      if (k == H_ACT - 1) chk("l0_last_addr", 32'(rd_addr), 32'd199);
    end
    blank_h();
    chk("l0_de_o_len", 32'(de_o_cnt - c_de), 32'd800);
    chk("l0_rd_en_len", 32'(rd_en_cnt - c_rd), 32'd800);

    for (int l = 1; l < 4; l++) short_line(l);
    step(1, 1, 0, 0);
    chk("l4_first_addr", 32'(rd_addr), 32'd200);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    for (int l = 5; l < 599; l++) short_line(l);
    for (int k = 0; k < H_ACT; k++) begin
      step(1, 1, 1'(k == 300), 0);
      if (k == 0) chk("l599_first_addr", 32'(rd_addr), 32'd29800);
      if (k == H_ACT - 1) chk("l599_last_addr", 32'(rd_addr), 32'd29999);
    end
    blank_h();
    step(0, 0, 0, 0);
    chk("frame_end_pulse", 32'(frame_end), 32'd1);
    step(0, 0, 0, 0);
    chk("frame_end_clear", 32'(frame_end), 32'd0);
    vblank();

    // Frame B, line 0 overruns to 900 pixels
    for (int k = 0; k < 900; k++) begin
      step(1, 1, 0, 0);
      if (k == 0) chk("fB_first_addr", 32'(rd_addr), 32'd0);
      if (k == 899) begin
        chk("ovr_addr_sat", 32'(rd_addr), 32'd199);
        chk("ovr_px_x_sat", 32'(px_x), 32'd799);
        chk("ovr_px_y", 32'(px_y), 32'd0);
      end
    end
    blank_h();
    for (int l = 1; l < 50; l++) short_line(l);
    for (int k = 0; k < 300; k++) step(1, 1, 0, 0);
    chk("l50_addr", 32'(rd_addr), 32'd2474);
    chk("l50_px_x", 32'(px_x), 32'd297);
    chk("l50_px_y", 32'(px_y), 32'd50);

    // Asynchronous reset mid-line
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    hen = 1'b0; ven = 1'b0;
    @(posedge clk_px); #1;
    @(posedge clk_px); #1;
    rst = 1'b0;
    vblank();

    // Frame C restarts from address 0
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 0, 0);
      if (k == 0) chk("fC_first_addr", 32'(rd_addr), 32'd0);
      if (k == 2) chk("fC_first_px_y", 32'(px_y), 32'd0);
      if (k == 4) chk("fC_addr_px4", 32'(rd_addr), 32'd1);
      if (k == 6) chk("fC_rgb_px4", 32'(rgb), 32'd42);
    end
    blank_h();
    for (int i = 0; i < 4; i++) step(0, 0, 1'(i == 1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
